// File: rtl/mips_pkg.sv
// Shared opcodes, forwarding-select encodings, instruction field positions and the
// per-stage record used by the decode/hazard stage.
package mips_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_ADDI = 5'h11;
  localparam logic [4:0] OP_SUBI = 5'h12;
  localparam logic [4:0] OP_LD   = 5'h18;
  localparam logic [4:0] OP_ST   = 5'h19;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_DM  = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  localparam int OP_HI = 19;
  localparam int OP_LO = 15;
  localparam int RD_HI = 14;
  localparam int RD_LO = 10;
  localparam int RA_HI = 9;
  localparam int RA_LO = 5;
  localparam int RB_HI = 4;
  localparam int RB_LO = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] opcode;
    logic [4:0] rd;
    logic       writes_rd;
    logic       is_load;
  } stage_t;

  // Youngest producer wins; a source the instruction does not read is never forwarded.
  function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t dm,
                                         input stage_t wb, input logic [4:0] src,
                                         input logic used);
    logic [1:0] sel;
    sel = SEL_REG;
    if (used) begin
      if (ex.valid && ex.writes_rd && ex.rd == src)      sel = SEL_EX;
      else if (dm.valid && dm.writes_rd && dm.rd == src) sel = SEL_DM;
      else if (wb.valid && wb.writes_rd && wb.rd == src) sel = SEL_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ins_decode.sv
// Opcode classifier for the ID-stage instruction; anything not in the ISA behaves as NOP.
module ins_decode
  import mips_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [4:0] op_norm,
  output logic       writes_rd,
  output logic       uses_a,
  output logic       uses_b,
  output logic       is_load,
  output logic       imm_sel
);

  always_comb begin
    op_norm   = opcode;
    writes_rd = 1'b0;
    uses_a    = 1'b1;
    uses_b    = 1'b0;
    is_load   = 1'b0;
    imm_sel   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        writes_rd = 1'b1;
        uses_b    = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        writes_rd = 1'b1;
        imm_sel   = 1'b1;
      end
      OP_LD: begin
        writes_rd = 1'b1;
        imm_sel   = 1'b1;
        is_load   = 1'b1;
      end
      OP_ST: uses_b = 1'b1;
      default: begin
        op_norm = OP_NOP;
        uses_a  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode/hazard stage: holds the ID instruction, tracks EX/DM/WB destinations, registers
// forwarding selects and immediates for the EX cycle, and stalls fetch on load-use.
module fwd_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DW     = 8,
  parameter int IW     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     ins_in,
  input  logic              ins_in_valid,
  output logic              stall,
  output logic [IW-1:0]     ins,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic              imm_sel,
  output logic [DW-1:0]     imm,
  output logic [4:0]        alu_op,
  output logic [REG_AW-1:0] RW_dm,
  output logic              wr_dm
);

  logic [IW-1:0] id_ins_q, id_ins_d;
  stage_t        ex_q, ex_d, dm_q, dm_d, wb_q, wb_d;
  logic [1:0]    sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic          imm_sel_q, imm_sel_d;
  logic [DW-1:0] imm_q, imm_d;

  logic [4:0] dec_op;
  logic       dec_writes, dec_uses_a, dec_uses_b, dec_load, dec_imm_sel;
  logic [4:0] rs_a, rs_b;

  assign rs_a = id_ins_q[RA_HI:RA_LO];
  assign rs_b = id_ins_q[RB_HI:RB_LO];

  ins_decode u_dec (
    .opcode    (id_ins_q[OP_HI:OP_LO]),
    .op_norm   (dec_op),
    .writes_rd (dec_writes),
    .uses_a    (dec_uses_a),
    .uses_b    (dec_uses_b),
    .is_load   (dec_load),
    .imm_sel   (dec_imm_sel)
  );

  // The loaded value is not available until the LD reaches DM, so hold ID for one cycle.
  assign stall = ex_q.valid && ex_q.is_load && ex_q.writes_rd &&
                 ((dec_uses_a && rs_a == ex_q.rd) || (dec_uses_b && rs_b == ex_q.rd));

  always_comb begin
    id_ins_d  = id_ins_q;
    wb_d      = dm_q;
    dm_d      = ex_q;
    ex_d      = '0;
    sel_a_d   = SEL_REG;
    sel_b_d   = SEL_REG;
    imm_sel_d = 1'b0;
    imm_d     = '0;
    if (!stall) begin
      ex_d.valid     = 1'b1;
      ex_d.opcode    = dec_op;
      ex_d.rd        = id_ins_q[RD_HI:RD_LO];
      ex_d.writes_rd = dec_writes;
      ex_d.is_load   = dec_load;
      sel_a_d        = fwd_sel(ex_q, dm_q, wb_q, rs_a, dec_uses_a);
      sel_b_d        = fwd_sel(ex_q, dm_q, wb_q, rs_b, dec_uses_b);
      imm_sel_d      = dec_imm_sel;
      imm_d          = {{(DW-5){id_ins_q[RB_HI]}}, id_ins_q[RB_HI:RB_LO]};
      id_ins_d       = ins_in_valid ? ins_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ins_q  <= '0;
      ex_q      <= '0;
      dm_q      <= '0;
      wb_q      <= '0;
      sel_a_q   <= SEL_REG;
      sel_b_q   <= SEL_REG;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
    end else begin
      id_ins_q  <= id_ins_d;
      ex_q      <= ex_d;
      dm_q      <= dm_d;
      wb_q      <= wb_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      imm_sel_q <= imm_sel_d;
      imm_q     <= imm_d;
    end
  end

  // WB only serves as a forwarding source; its opcode and load flag are never consumed.
  logic wb_unused;
  assign wb_unused = ^{wb_q.opcode, wb_q.is_load};

  assign ins       = id_ins_q;
  assign mux_sel_A = sel_a_q;
  assign mux_sel_B = sel_b_q;
  assign imm_sel   = imm_sel_q;
  assign imm       = imm_q;
  assign alu_op    = ex_q.opcode;
  assign wr_dm     = dm_q.valid && dm_q.writes_rd;
  assign RW_dm     = wr_dm ? dm_q.rd : '0;

endmodule
